// File: rtl/eightbit_pkg.sv
// Shared encodings for the 8-bit core.
// Covers instruction types, ALU ops, execute FSM states and page defaults.
package eightbit_pkg;

   typedef enum logic [1:0] {
      IT_JMP   = 2'b00,
      IT_LOAD  = 2'b01,
      IT_STORE = 2'b10,
      IT_ALU   = 2'b11
   } inst_t;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_NAND = 2'b10,
      OP_MOV  = 2'b11
   } alu_op_t;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_MEM_RD  = 3'd1;
   localparam logic [2:0] S_MEM_CAP = 3'd2;
   localparam logic [2:0] S_MEM_WR  = 3'd3;
   localparam logic [2:0] S_RETIRE  = 3'd4;

   localparam logic [1:0] DATA_PAGE_DEF = 2'b01;
   localparam logic [1:0] JUMP_PAGE_DEF = 2'b00;

endpackage

// File: rtl/execute_unit_if.sv
// Data-memory port of the execute stage.
// The master drives address, write data and write enable.
interface execute_unit_if;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       mem_we;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      output mem_rdata
   );
endinterface

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage.
// The carry flag only moves for ADD/SUB; carry_valid says when.
module exec_alu
   import eightbit_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [1:0] op,
   input  logic       srcdst,
   output logic [7:0] result,
   output logic       carry,
   output logic       carry_valid
);

   logic [8:0] sum;
   logic [8:0] dif;

   assign sum = {1'b0, a} + {1'b0, b};
   // Bit 8 of the 9-bit difference is the unsigned borrow
   assign dif = {1'b0, a} - {1'b0, b};

   always_comb begin
      result      = '0;
      carry       = 1'b0;
      carry_valid = 1'b0;
      unique case (1'b1)
         op == OP_ADD: begin
            result      = sum[7:0];
            carry       = sum[8];
            carry_valid = 1'b1;
         end
         op == OP_SUB: begin
            result      = dif[7:0];
            carry       = dif[8];
            carry_valid = 1'b1;
         end
         op == OP_NAND: result = ~(a & b);
         default:       result = srcdst ? a : b;
      endcase
   end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: owns A/B, Z/C, the data-memory port and next-PC.
// One instruction in flight; en while busy is dropped.
module execute_unit
   import eightbit_pkg::*;
#(
   parameter logic [1:0] DATA_PAGE = DATA_PAGE_DEF,
   parameter logic [1:0] JUMP_PAGE = JUMP_PAGE_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [1:0]     inst_type,
   input  logic [5:0]     addr,
   input  logic           srcdst,
   input  logic [7:0]     pc_in,
   execute_unit_if.master dbus,
   output logic           busy,
   output logic           done,
   output logic [7:0]     pc_next,
   output logic [7:0]     a_out,
   output logic [7:0]     b_out,
   output logic           flag_z,
   output logic           flag_c
);

   logic [2:0] state;
   logic [7:0] a_q, b_q;
   logic       z_q, c_q, sd_q;
   logic [7:0] alu_res;
   logic       alu_c, alu_cv;
   logic [7:0] sel_reg;

   exec_alu u_alu (
      .a           (a_q),
      .b           (b_q),
      .op          (addr[1:0]),
      .srcdst      (srcdst),
      .result      (alu_res),
      .carry       (alu_c),
      .carry_valid (alu_cv)
   );

   assign sel_reg = srcdst ? b_q : a_q;
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_RETIRE);
   assign a_out   = a_q;
   assign b_out   = b_q;
   assign flag_z  = z_q;
   assign flag_c  = c_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         a_q            <= '0;
         b_q            <= '0;
         z_q            <= 1'b0;
         c_q            <= 1'b0;
         sd_q           <= 1'b0;
         pc_next        <= '0;
         dbus.mem_addr  <= '0;
         dbus.mem_wdata <= '0;
         dbus.mem_we    <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: if (en) begin
               sd_q    <= srcdst;
               pc_next <= (inst_type == IT_JMP) ?
                          {JUMP_PAGE, addr} : pc_in + 8'd1;
               // JMP/ALU finish on this edge; memory ops start their access
               unique case (1'b1)
                  inst_type == IT_JMP: state <= S_RETIRE;
                  inst_type == IT_ALU: begin
                     state <= S_RETIRE;
                     if (srcdst) b_q <= alu_res;
                     else        a_q <= alu_res;
                     z_q <= (alu_res == 8'h00);
                     if (alu_cv) c_q <= alu_c;
                  end
                  inst_type == IT_STORE: begin
                     state          <= S_MEM_WR;
                     dbus.mem_addr  <= {DATA_PAGE, addr};
                     dbus.mem_wdata <= sel_reg;
                     dbus.mem_we    <= 1'b1;
                  end
                  default: begin
                     state         <= S_MEM_RD;
                     dbus.mem_addr <= {DATA_PAGE, addr};
                  end
               endcase
            end
            S_MEM_RD: state <= S_MEM_CAP;
            S_MEM_CAP: begin
               state <= S_RETIRE;
               if (sd_q) b_q <= dbus.mem_rdata;
               else      a_q <= dbus.mem_rdata;
               z_q <= (dbus.mem_rdata == 8'h00);
            end
            S_MEM_WR: begin
               state       <= S_RETIRE;
               dbus.mem_we <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit against a behavioural model.
// Directed scenarios followed by random instruction streams.
module tb_execute_unit;
   import eightbit_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] inst_type = 2'b00;
   logic [5:0] addr = 6'h00;
   logic       srcdst = 1'b0;
   logic [7:0] pc_in = 8'h00;
   logic       busy, done, flag_z, flag_c;
   logic [7:0] pc_next, a_out, b_out;

   execute_unit_if mif ();

   execute_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .inst_type (inst_type),
      .addr      (addr),
      .srcdst    (srcdst),
      .pc_in     (pc_in),
      .dbus      (mif),
      .busy      (busy),
      .done      (done),
      .pc_next   (pc_next),
      .a_out     (a_out),
      .b_out     (b_out),
      .flag_z    (flag_z),
      .flag_c    (flag_c)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] a;
      logic [7:0] b;
      logic       z;
      logic       c;
      int         acc;
      int         lat;
   } exp_t;

   typedef struct {
      logic [7:0] ad;
      logic [7:0] wd;
   } st_t;

   exp_t sb[$];
   st_t  stq[$];

   int total = 0;
   int passed = 0;
   int cyc = 0;

   logic [7:0] dmem [256];
   logic [7:0] rmem [256];
   logic [7:0] ma = 8'h00, mb = 8'h00;
   logic       mz = 1'b0, mc = 1'b0;

   function automatic logic [7:0] seed(input int i);
      case (i)
         8'h45:   return 8'h00;
         8'h50:   return 8'hF0;
         8'h51:   return 8'h20;
         8'h52:   return 8'h10;
         8'h60:   return 8'h7E;
         default: return 8'(i * 37 + 11);
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAM; contents reload while reset is held
   always @(posedge clk) begin
      mif.mem_rdata <= dmem[mif.mem_addr];
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) dmem[i] <= seed(i);
      end else if (mif.mem_we) begin
         dmem[mif.mem_addr] <= mif.mem_wdata;
      end
   end

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 8'h01, 8'h00);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("pc_next", pc_next, e.pc);
               chk("reg_a", a_out, e.a);
               chk("reg_b", b_out, e.b);
               chk("flag_z", {7'b0, flag_z}, {7'b0, e.z});
               chk("flag_c", {7'b0, flag_c}, {7'b0, e.c});
               chk("latency", 8'(cyc - e.acc + 1), 8'(e.lat));
            end
         end
         if (mif.mem_we) begin
            if (stq.size() == 0) begin
               chk("spurious_we", 8'h01, 8'h00);
            end else begin
               st_t s;
               s = stq.pop_front();
               chk("st_addr", mif.mem_addr, s.ad);
               chk("st_wdata", mif.mem_wdata, s.wd);
            end
         end
      end
   end

   task automatic model_reset();
      ma = 8'h00;
      mb = 8'h00;
      mz = 1'b0;
      mc = 1'b0;
      for (int i = 0; i < 256; i++) rmem[i] = seed(i);
   endtask

   task automatic issue(input logic [1:0] t, input logic [5:0] ad,
                        input logic sd, input logic [7:0] pc,
                        input bit poke);
      exp_t e;
      st_t  s;
      int   n;
      int   tmp;
      logic [7:0] res;
      @(negedge clk);
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", {7'b0, busy}, 8'h00);
      e.pc  = (t == 2'b00) ? {2'b00, ad} : 8'((int'(pc) + 1) % 256);
      e.lat = 1;
      case (t)
         2'b01: begin
            e.lat = 3;
            res = rmem[{2'b01, ad}];
            if (sd) mb = res;
            else    ma = res;
            mz = (res == 8'h00);
         end
         2'b10: begin
            e.lat = 2;
            s.ad = {2'b01, ad};
            s.wd = sd ? mb : ma;
            rmem[s.ad] = s.wd;
            stq.push_back(s);
         end
         2'b11: begin
            case (ad[1:0])
               2'b00: begin
                  tmp = int'(ma) + int'(mb);
                  res = 8'(tmp % 256);
                  mc  = (tmp > 255);
               end
               2'b01: begin
                  tmp = int'(ma) - int'(mb);
                  res = 8'((tmp + 256) % 256);
                  mc  = (tmp < 0);
               end
               2'b10:   res = ~(ma & mb);
               default: res = sd ? ma : mb;
            endcase
            if (sd) mb = res;
            else    ma = res;
            mz = (res == 8'h00);
         end
         default: ;
      endcase
      e.a = ma;
      e.b = mb;
      e.z = mz;
      e.c = mc;
      en = 1'b1;
      inst_type = t;
      addr = ad;
      srcdst = sd;
      pc_in = pc;
      @(posedge clk);
      #1;
      e.acc = cyc;
      sb.push_back(e);
      en = 1'b0;
      if (t == 2'b01) chk("rd_addr", mif.mem_addr, {2'b01, ad});
      if (poke) begin
         @(negedge clk);
         en = 1'b1;
         inst_type = 2'($urandom);
         addr = 6'($urandom);
         srcdst = 1'($urandom);
         pc_in = 8'($urandom);
         @(posedge clk);
         #1;
         en = 1'b0;
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_a"}, a_out, 8'h00);
      chk({nm, "_b"}, b_out, 8'h00);
      chk({nm, "_pc"}, pc_next, 8'h00);
      chk({nm, "_maddr"}, mif.mem_addr, 8'h00);
      chk({nm, "_wdata"}, mif.mem_wdata, 8'h00);
      chk({nm, "_ctl"}, {3'b0, mif.mem_we, busy, done, flag_z, flag_c},
          8'h00);
   endtask

   initial begin
      int n;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while a LOAD sits in MEM_CAP
      issue(2'b01, 6'h10, 1'b0, 8'h33, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      sb.delete();
      stq.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      issue(2'b00, 6'h2A, 1'b0, 8'h10, 1'b0);
      issue(2'b01, 6'h05, 1'b1, 8'h20, 1'b0);
      issue(2'b01, 6'h10, 1'b0, 8'h21, 1'b0);
      issue(2'b01, 6'h11, 1'b1, 8'h22, 1'b0);
      issue(2'b11, 6'h00, 1'b0, 8'h23, 1'b0);
      issue(2'b01, 6'h12, 1'b1, 8'h24, 1'b0);
      issue(2'b11, 6'h01, 1'b0, 8'h25, 1'b0);
      issue(2'b01, 6'h20, 1'b0, 8'h26, 1'b0);
      issue(2'b10, 6'h3F, 1'b0, 8'h27, 1'b0);
      issue(2'b11, 6'h3E, 1'b1, 8'hFF, 1'b0);
      issue(2'b01, 6'h3F, 1'b1, 8'h40, 1'b1);

      for (int i = 0; i < 120; i++) begin
         logic [1:0] t;
         t = 2'($urandom);
         issue(t, 6'($urandom), 1'($urandom), 8'($urandom),
               (t == 2'b01) && ($urandom_range(0, 1) == 1));
      end

      n = 0;
      while ((sb.size() != 0 || stq.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_sb", 8'(sb.size()), 8'h00);
      chk("drain_st", 8'(stq.size()), 8'h00);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
